// File: rtl/game_flow_controller.sv
// Phase sequencer for the box-and-pipe game: tracks game state, keeps the BCD score
// and steps the tick generator's speed select as the player levels up.
module game_flow_controller #(
  parameter int LEVEL_STEP   = 5,
  parameter int CRASH_CYCLES = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       collided,
  input  logic       pipe_passed,
  output logic [2:0] clk_speed,
  output logic       freeze,
  output logic       clock_clear,
  output logic       run,
  output logic [2:0] state,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [1:0] level
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    CRASH = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_startPrev;
  logic        r_pausePrev;
  logic        r_clearPulse;
  logic [3:0]  r_scoreTens;
  logic [3:0]  r_scoreOnes;
  logic [1:0]  r_level;
  logic [3:0]  r_pts;
  logic [24:0] r_crashCnt;

  logic w_startRise;
  logic w_pauseRise;
  logic w_startAccept;
  logic w_pointAccept;
  logic w_scoreMax;
  logic w_crashDone;

  assign w_startRise   = start & ~r_startPrev;
  assign w_pauseRise   = pause & ~r_pausePrev;
  assign w_startAccept = w_startRise & ((r_state == IDLE) | (r_state == OVER));
  assign w_scoreMax    = (r_scoreTens == 4'd9) & (r_scoreOnes == 4'd9);
  // A collision in the same cycle wins over the pipe pass; the score freezes at 99.
  assign w_pointAccept = (r_state == RUN) & pipe_passed & ~collided & ~w_scoreMax;
  assign w_crashDone   = (r_crashCnt == 25'(CRASH_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_startRise) w_stateNext = RUN;
      RUN: begin
        if (collided)         w_stateNext = CRASH;
        else if (w_pauseRise) w_stateNext = PAUSE;
      end
      PAUSE:   if (w_pauseRise) w_stateNext = RUN;
      CRASH:   if (w_crashDone) w_stateNext = OVER;
      OVER:    if (w_startRise) w_stateNext = RUN;
      default: w_stateNext = IDLE;
    endcase
  end

  // Key history resets high so a key held through reset needs a fresh press.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_startPrev  <= 1'b1;
      r_pausePrev  <= 1'b1;
      r_clearPulse <= 1'b0;
      r_scoreTens  <= 4'd0;
      r_scoreOnes  <= 4'd0;
      r_level      <= 2'd0;
      r_pts        <= 4'd0;
      r_crashCnt   <= 25'd0;
    end else begin
      r_startPrev  <= start;
      r_pausePrev  <= pause;
      r_clearPulse <= w_startAccept;
      if (w_startAccept) begin
        r_scoreTens <= 4'd0;
        r_scoreOnes <= 4'd0;
        r_level     <= 2'd0;
        r_pts       <= 4'd0;
      end else if (w_pointAccept) begin
        if (r_scoreOnes == 4'd9) begin
          r_scoreOnes <= 4'd0;
          r_scoreTens <= r_scoreTens + 4'd1;
        end else begin
          r_scoreOnes <= r_scoreOnes + 4'd1;
        end
        if (r_pts == 4'(LEVEL_STEP - 1)) begin
          r_pts <= 4'd0;
          if (r_level != 2'd3) r_level <= r_level + 2'd1;
        end else begin
          r_pts <= r_pts + 4'd1;
        end
      end
      if ((r_state == RUN) && collided) r_crashCnt <= 25'd0;
      else if (r_state == CRASH)        r_crashCnt <= r_crashCnt + 25'd1;
    end
  end

  always_comb begin
    run         = (r_state == RUN);
    freeze      = (r_state != RUN);
    clk_speed   = {1'b0, r_level} + 3'd1;
    clock_clear = (r_state == IDLE) | r_clearPulse;
    state       = r_state;
    score_tens  = r_scoreTens;
    score_ones  = r_scoreOnes;
    level       = r_level;
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a short crash window (CRASH_CYCLES = 4)
// and LEVEL_STEP = 5; every expected value below is worked out by hand.
module tb_game_flow_controller;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic       pause;
  logic       collided;
  logic       pipe_passed;
  logic [2:0] clk_speed;
  logic       freeze;
  logic       clock_clear;
  logic       run;
  logic [2:0] state;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [1:0] level;

  int checkCount = 0;
  int errorCount = 0;

  game_flow_controller #(.LEVEL_STEP(5), .CRASH_CYCLES(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .collided    (collided),
    .pipe_passed (pipe_passed),
    .clk_speed   (clk_speed),
    .freeze      (freeze),
    .clock_clear (clock_clear),
    .run         (run),
    .state       (state),
    .score_tens  (score_tens),
    .score_ones  (score_ones),
    .level       (level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one edge; inputs change and outputs are read 1 time unit after it.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic pipePulses(input int count);
    for (int i = 0; i < count; i++) begin
      pipe_passed = 1'b1;
      applyStimulus(1);
      pipe_passed = 1'b0;
    end
  endtask

  function automatic int scoreBcd();
    return {24'd0, score_tens, score_ones};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b1; pause = 1'b0; collided = 1'b0; pipe_passed = 1'b0;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_run", run, 0);
    checkOutput("reset_freeze", freeze, 1);
    checkOutput("reset_clear", clock_clear, 1);
    checkOutput("reset_speed", clk_speed, 1);
    checkOutput("reset_score", scoreBcd(), 'h00);
    applyStimulus(2);
    checkOutput("held_start_ignored", state, 0);

    start = 1'b0;
    applyStimulus(1);
    start = 1'b1;
    applyStimulus(1);
    checkOutput("start_state", state, 1);
    checkOutput("start_run", run, 1);
    checkOutput("start_freeze", freeze, 0);
    checkOutput("start_clear_pulse", clock_clear, 1);
    applyStimulus(1);
    checkOutput("clear_pulse_end", clock_clear, 0);
    checkOutput("held_start_in_run", state, 1);

    pipePulses(5);
    checkOutput("score_05", scoreBcd(), 'h05);
    checkOutput("level_1", level, 1);
    checkOutput("speed_2", clk_speed, 2);
    pipePulses(10);
    checkOutput("score_15", scoreBcd(), 'h15);
    checkOutput("level_3", level, 3);
    checkOutput("speed_4", clk_speed, 4);
    pipePulses(5);
    checkOutput("score_20", scoreBcd(), 'h20);
    checkOutput("level_sat", level, 3);
    pipePulses(78);
    checkOutput("score_98", scoreBcd(), 'h98);
    pipePulses(3);
    checkOutput("score_tens_99", score_tens, 9);
    checkOutput("score_ones_99", score_ones, 9);
    checkOutput("level_at_99", level, 3);

    collided = 1'b1; pipe_passed = 1'b1;
    applyStimulus(1);
    collided = 1'b0; pipe_passed = 1'b0;
    checkOutput("crash_state", state, 3);
    checkOutput("crash_run", run, 0);
    checkOutput("crash_freeze", freeze, 1);
    checkOutput("crash_score_held", scoreBcd(), 'h99);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("crash_cycle_%0d", i), state, 3);
    end
    applyStimulus(1);
    checkOutput("over_state", state, 4);
    checkOutput("over_score", scoreBcd(), 'h99);
    checkOutput("over_level", level, 3);

    start = 1'b0;
    applyStimulus(1);
    start = 1'b1;
    applyStimulus(1);
    checkOutput("restart_state", state, 1);
    checkOutput("restart_score", scoreBcd(), 'h00);
    checkOutput("restart_level", level, 0);
    checkOutput("restart_clear", clock_clear, 1);
    applyStimulus(1);
    checkOutput("restart_clear_end", clock_clear, 0);

    pause = 1'b1;
    applyStimulus(1);
    checkOutput("pause_state", state, 2);
    checkOutput("pause_freeze", freeze, 1);
    pipe_passed = 1'b1; collided = 1'b1;
    applyStimulus(1);
    pipe_passed = 1'b0; collided = 1'b0;
    checkOutput("pause_ignores_inputs", state, 2);
    checkOutput("pause_score_held", scoreBcd(), 'h00);
    applyStimulus(1);
    checkOutput("pause_held_key", state, 2);
    pause = 1'b0;
    applyStimulus(1);
    pause = 1'b1;
    applyStimulus(1);
    checkOutput("resume_state", state, 1);
    checkOutput("resume_freeze", freeze, 0);
    pause = 1'b0;
    applyStimulus(1);
    pause = 1'b1; pipe_passed = 1'b1;
    applyStimulus(1);
    pipe_passed = 1'b0;
    checkOutput("pause_with_point_state", state, 2);
    checkOutput("pause_with_point_score", scoreBcd(), 'h01);
    pause = 1'b0;
    applyStimulus(1);
    pause = 1'b1;
    applyStimulus(1);
    checkOutput("resume_again", state, 1);

    pipePulses(36);
    checkOutput("score_37", scoreBcd(), 'h37);
    checkOutput("level_at_37", level, 3);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("midrun_reset_state", state, 0);
    checkOutput("midrun_reset_score", scoreBcd(), 'h00);
    checkOutput("midrun_reset_level", level, 0);
    checkOutput("midrun_reset_speed", clk_speed, 1);
    checkOutput("midrun_reset_clear", clock_clear, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level sequencer for the tick generator in the box-and-pipe game. Tracks game phase (idle, running, paused, crashed, over), keeps a two-digit BCD score, and raises difficulty by stepping the tick generator's speed select as the score grows. Sits between the player keys, the collision and pipe-pass detectors, and the tick generator, driving its speed select, freeze and clear inputs.

## Interface

- LEVEL_STEP, 5, points per difficulty level, 1..15
- CRASH_CYCLES, 25_000_000, CLOCK_50 cycles spent in CRASH before OVER, ≥1, counter width 25 bits
- CLOCK_50  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge CLOCK_50
- start  in  1  player key, level; rising edge detected internally
- pause  in  1  player key, level; rising edge detected internally
- collided  in  1  box/pipe collision, level
- pipe_passed  in  1  single-cycle pulse per pipe cleared
- clk_speed  out  3  speed select to tick generator, 1..4
- freeze  out  1  to tick generator's collided input; 1 = tick counting stopped
- clock_clear  out  1  to tick generator's key_press input; 1 = clear count
- run  out  1  1 only in RUN; gates game motion
- state  out  3  0 IDLE, 1 RUN, 2 PAUSE, 3 CRASH, 4 OVER
- score_tens, score_ones  out  4 each  BCD score, 00..99
- level  out  2  difficulty level, 0..3

## Operation

- Edge detect: start_prev/pause_prev registers; a key rises when it is high now and its _prev register is low. Both _prev registers reset to 1, so a key held through reset does not trigger.
- State decode: run = (RUN); freeze = not RUN; clk_speed = 1 + level in all states; clock_clear = (IDLE) OR clear_pulse.
- IDLE: start rise -> RUN; clear score to 00, level to 0, pts counter to 0; set clear_pulse.
- RUN:
  - collided -> CRASH; load crash counter with 0.
  - Else pause rise -> PAUSE.
  - pipe_passed with no collided in the same cycle: score +1 in BCD (ones 9 -> 0 with tens +1). Applies even when pause rises in the same cycle.
  - pts counter +1 on each accepted point; on reaching LEVEL_STEP: pts -> 0 and level +1, saturating at 3 (pts still wraps).
  - At score 99, pipe_passed is ignored: score, pts and level all unchanged.
  - start is ignored.
- PAUSE: pause rise -> RUN. collided, pipe_passed and start are ignored.
- CRASH: crash counter +1 per cycle; at CRASH_CYCLES-1 -> OVER. All inputs are ignored.
- OVER: score and level held. start rise -> RUN with the same clearing as IDLE -> RUN, including clear_pulse.
- clear_pulse: registered; high for exactly one cycle after the edge that accepted start.
- reset (any state, including mid-RUN or mid-CRASH): state IDLE, score 00, level 0, pts 0, crash counter 0, clear_pulse 0, start_prev = pause_prev = 1.

## Timing

- Reset values on the cycle after the reset edge: state 0, run 0, freeze 1, clock_clear 1, clk_speed 1, score 00, level 0.
- Start rise sampled at edge k:
  - state = RUN, run = 1, freeze = 0 after edge k.
  - clock_clear = 1 (clear_pulse) for the cycle between edges k and k+1, then 0.
- pipe_passed at edge k: score, level and clk_speed update after edge k (1-cycle latency).
- collided at edge k: run = 0, freeze = 1 after edge k.
  - state = CRASH for exactly CRASH_CYCLES cycles, then OVER.
- Pause rise at edge k: state and freeze change after edge k. A second rise is needed to resume; a held pause key counts as one rise.
- All outputs are registered-state decodes; no combinational input-to-output paths.

## Test plan

- Assert reset for 2 cycles with start held high, then release reset -> state 0, clock_clear 1, freeze 1, clk_speed 1, score 00; no start accepted until start falls and rises again.
- Start rise from IDLE -> state 1 next cycle, clock_clear high exactly 1 cycle, freeze 0. Then 5 pipe_passed pulses (LEVEL_STEP = 5) -> score 05, level 1, clk_speed 2. 10 more pulses -> score 15, level 3, clk_speed 4. 5 more pulses -> score 20, level stays 3.
- Preload to score 98 via pulses, then 3 pulses -> score 99, held at 99; score_tens 9, score_ones 9.
- Run with CRASH_CYCLES = 4; collided and pipe_passed in the same cycle -> score unchanged, state 3 for 4 cycles, then 4. Start rise -> state 1, score 00, level 0, clock_clear 1-cycle pulse.
- Pause rise -> state 2, freeze 1, pipe_passed and collided ignored. Pause rise again -> state 1, freeze 0. Pause rise coincident with pipe_passed -> score +1 and state 2.
- Assert reset mid-RUN at score 37, level 3 -> next cycle state 0, score 00, level 0, clk_speed 1.
